// File: rtl/core_bus_ctrl_pkg.sv
// Shared types and limits for the external bus controller.
// Holds the FSM states, request-type codes and the strobe-wait range.
package core_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LATCH,
        ST_STRB,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        RQ_NONE,
        RQ_ROM,
        RQ_RDR,
        RQ_WRR
    } req_e;

    localparam int unsigned STROBE_WAIT_MAX = 7;
    localparam int unsigned WAIT_CNT_W      = 3;

    function automatic logic is_read(input req_e rq);
        return (rq == RQ_ROM) || (rq == RQ_RDR);
    endfunction

endpackage

// File: rtl/core_bus_ctrl_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Both flops reset to RESET_VAL so the output is defined during reset.
module core_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/core_bus_ctrl.sv
// External-bus responder: runs 8051-style multiplexed ROM/RAM cycles
// (ALE, PSEN_b, RD_b, WR_b) for the memory controller; all outputs registered.
module core_bus_ctrl
    import core_bus_ctrl_pkg::*;
#(
    parameter int unsigned STROBE_WAIT = 1
) (
    input  logic        bus_ctrl_clk_i,
    input  logic        bus_ctrl_rst_i,
    input  logic        bus_ctrl_ext_rom_rd_b_i,
    input  logic        bus_ctrl_ext_ram_rd_b_i,
    input  logic        bus_ctrl_ext_ram_wr_b_i,
    input  logic [15:0] bus_ctrl_addr_i,
    input  logic [7:0]  bus_ctrl_data_i,
    output logic [7:0]  bus_ctrl_data_o,
    output logic        bus_ctrl_busy_o,
    output logic        bus_ctrl_done_o,
    input  logic        bus_ctrl_ea_b_pin_i,
    output logic        bus_ctrl_ea_b_o,
    input  logic [7:0]  bus_ctrl_p0_i,
    output logic [7:0]  bus_ctrl_p0_o,
    output logic        bus_ctrl_p0_oe_o,
    output logic [7:0]  bus_ctrl_p2_o,
    output logic        bus_ctrl_ale_o,
    output logic        bus_ctrl_psen_b_o,
    output logic        bus_ctrl_rd_b_o,
    output logic        bus_ctrl_wr_b_o
);

    // Out-of-range wait values saturate rather than overflow the counter.
    localparam int unsigned STRB_LAST =
        (STROBE_WAIT > STROBE_WAIT_MAX) ? STROBE_WAIT_MAX : STROBE_WAIT;
    localparam logic [WAIT_CNT_W-1:0] STRB_LAST_CNT = WAIT_CNT_W'(STRB_LAST);

    state_e                state_q;
    req_e                  type_q;
    logic [15:0]           addr_q;
    logic [7:0]            wdata_q;
    logic [WAIT_CNT_W-1:0] wait_q;

    logic                  rom_prev_q;
    logic                  rdr_prev_q;
    logic                  wrr_prev_q;
    logic [15:0]           last_rom_q;
    logic [15:0]           last_rdr_q;
    logic [15:0]           last_wrr_q;

    logic [7:0]            data_q;
    logic                  busy_q;
    logic                  done_q;
    logic [7:0]            p0_q;
    logic                  p0_oe_q;
    logic [7:0]            p2_q;
    logic                  ale_q;
    logic                  psen_b_q;
    logic                  rd_b_q;
    logic                  wr_b_q;

    logic                  rom_req;
    logic                  rdr_req;
    logic                  wrr_req;
    req_e                  req_d;

    // A held-low strobe only re-runs when its address moved since the last completion.
    assign rom_req = !bus_ctrl_ext_rom_rd_b_i &&
                     (rom_prev_q || (bus_ctrl_addr_i != last_rom_q));
    assign rdr_req = !bus_ctrl_ext_ram_rd_b_i &&
                     (rdr_prev_q || (bus_ctrl_addr_i != last_rdr_q));
    assign wrr_req = !bus_ctrl_ext_ram_wr_b_i &&
                     (wrr_prev_q || (bus_ctrl_addr_i != last_wrr_q));

    always_comb begin
        req_d = RQ_NONE;
        if (rom_req) begin
            req_d = RQ_ROM;
        end else if (rdr_req) begin
            req_d = RQ_RDR;
        end else if (wrr_req) begin
            req_d = RQ_WRR;
        end
    end

    always_ff @(posedge bus_ctrl_clk_i or posedge bus_ctrl_rst_i) begin
        if (bus_ctrl_rst_i) begin
            state_q    <= ST_IDLE;
            type_q     <= RQ_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_q     <= '0;
            rom_prev_q <= 1'b1;
            rdr_prev_q <= 1'b1;
            wrr_prev_q <= 1'b1;
            last_rom_q <= '0;
            last_rdr_q <= '0;
            last_wrr_q <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            p0_q       <= '0;
            p0_oe_q    <= 1'b0;
            p2_q       <= '0;
            ale_q      <= 1'b0;
            psen_b_q   <= 1'b1;
            rd_b_q     <= 1'b1;
            wr_b_q     <= 1'b1;
        end else begin
            rom_prev_q <= bus_ctrl_ext_rom_rd_b_i;
            rdr_prev_q <= bus_ctrl_ext_ram_rd_b_i;
            wrr_prev_q <= bus_ctrl_ext_ram_wr_b_i;
            done_q     <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (req_d != RQ_NONE) begin
                        state_q <= ST_ADDR;
                        type_q  <= req_d;
                        addr_q  <= bus_ctrl_addr_i;
                        wdata_q <= bus_ctrl_data_i;
                        busy_q  <= 1'b1;
                        ale_q   <= 1'b1;
                        p0_q    <= bus_ctrl_addr_i[7:0];
                        p0_oe_q <= 1'b1;
                        p2_q    <= bus_ctrl_addr_i[15:8];
                    end
                end

                ST_ADDR: begin
                    state_q <= ST_LATCH;
                    ale_q   <= 1'b0;
                    if (type_q == RQ_WRR) begin
                        p0_q    <= wdata_q;
                        p0_oe_q <= 1'b1;
                    end else begin
                        p0_oe_q <= 1'b0;
                    end
                end

                ST_LATCH: begin
                    state_q  <= ST_STRB;
                    wait_q   <= '0;
                    psen_b_q <= (type_q != RQ_ROM);
                    rd_b_q   <= (type_q != RQ_RDR);
                    wr_b_q   <= (type_q != RQ_WRR);
                end

                ST_STRB: begin
                    if (wait_q == STRB_LAST_CNT) begin
                        state_q  <= ST_HOLD;
                        psen_b_q <= 1'b1;
                        rd_b_q   <= 1'b1;
                        wr_b_q   <= 1'b1;
                        done_q   <= 1'b1;
                        if (is_read(type_q)) begin
                            data_q <= bus_ctrl_p0_i;
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end

                ST_HOLD: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    p0_oe_q <= 1'b0;
                    case (type_q)
                        RQ_ROM:  last_rom_q <= addr_q;
                        RQ_RDR:  last_rdr_q <= addr_q;
                        RQ_WRR:  last_wrr_q <= addr_q;
                        default: ;
                    endcase
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    core_sync2 #(
        .RESET_VAL(1'b1)
    ) u_ea_sync (
        .clk_i(bus_ctrl_clk_i),
        .rst_i(bus_ctrl_rst_i),
        .d_i  (bus_ctrl_ea_b_pin_i),
        .q_o  (bus_ctrl_ea_b_o)
    );

    assign bus_ctrl_data_o   = data_q;
    assign bus_ctrl_busy_o   = busy_q;
    assign bus_ctrl_done_o   = done_q;
    assign bus_ctrl_p0_o     = p0_q;
    assign bus_ctrl_p0_oe_o  = p0_oe_q;
    assign bus_ctrl_p2_o     = p2_q;
    assign bus_ctrl_ale_o    = ale_q;
    assign bus_ctrl_psen_b_o = psen_b_q;
    assign bus_ctrl_rd_b_o   = rd_b_q;
    assign bus_ctrl_wr_b_o   = wr_b_q;

endmodule

// File: tb/tb_core_bus_ctrl.sv
// Scoreboard bench for core_bus_ctrl: stimulus pushes expected transactions,
// a negedge monitor reconstructs each bus cycle from the pins and checks it.
module tb_core_bus_ctrl;

    localparam int SW = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_b = 1'b1;
    logic        rdr_b = 1'b1;
    logic        wrr_b = 1'b1;
    logic [15:0] addr = '0;
    logic [7:0]  wdat = '0;
    logic [7:0]  p0_in = '0;
    logic        ea_pin = 1'b1;

    logic [7:0]  data_o;
    logic        busy;
    logic        done;
    logic        ea_b;
    logic [7:0]  p0;
    logic        p0_oe;
    logic [7:0]  p2;
    logic        ale;
    logic        psen_b;
    logic        rd_b;
    logic        wr_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;   // 0 ROM read, 1 RAM read, 2 RAM write
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } txn_t;

    txn_t sb[$];

    always #5 clk = ~clk;

    core_bus_ctrl #(.STROBE_WAIT(SW)) dut (
        .bus_ctrl_clk_i         (clk),
        .bus_ctrl_rst_i         (rst),
        .bus_ctrl_ext_rom_rd_b_i(rom_b),
        .bus_ctrl_ext_ram_rd_b_i(rdr_b),
        .bus_ctrl_ext_ram_wr_b_i(wrr_b),
        .bus_ctrl_addr_i        (addr),
        .bus_ctrl_data_i        (wdat),
        .bus_ctrl_data_o        (data_o),
        .bus_ctrl_busy_o        (busy),
        .bus_ctrl_done_o        (done),
        .bus_ctrl_ea_b_pin_i    (ea_pin),
        .bus_ctrl_ea_b_o        (ea_b),
        .bus_ctrl_p0_i          (p0_in),
        .bus_ctrl_p0_o          (p0),
        .bus_ctrl_p0_oe_o       (p0_oe),
        .bus_ctrl_p2_o          (p2),
        .bus_ctrl_ale_o         (ale),
        .bus_ctrl_psen_b_o      (psen_b),
        .bus_ctrl_rd_b_o        (rd_b),
        .bus_ctrl_wr_b_o        (wr_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_strobe(input int kind, input logic lvl);
        case (kind)
            0:       rom_b = lvl;
            1:       rdr_b = lvl;
            default: wrr_b = lvl;
        endcase
    endtask

    task automatic issue(input int kind, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] r);
        txn_t e;
        e.kind  = kind;
        e.addr  = a;
        e.wdata = d;
        e.rdata = r;
        sb.push_back(e);
        addr  = a;
        wdat  = d;
        p0_in = r;
        set_strobe(kind, 1'b0);
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic do_txn(input int kind, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] r, input string name);
        issue(kind, a, d, r);
        wait_done(name);
        set_strobe(kind, 1'b1);
        @(negedge clk);
    endtask

    // Monitor: rebuild each bus cycle from the pins and compare at its done pulse.
    logic        mon_active = 1'b0;
    logic [15:0] m_addr;
    int          m_cyc, n_ale, n_psen, n_rd, n_wr;
    logic        overlap, wr_bad, rd_oe_bad;
    logic [7:0]  wr_p0;
    logic [7:0]  last_rd = '0;

    always @(negedge clk) begin
        txn_t e;
        if (rst) begin
            mon_active = 1'b0;
            last_rd    = '0;
        end else begin
            if (ale && !mon_active) begin
                mon_active = 1'b1;
                m_addr     = {p2, p0};
                m_cyc      = 0;
                n_ale      = 0;
                n_psen     = 0;
                n_rd       = 0;
                n_wr       = 0;
                overlap    = !p0_oe;
                wr_bad     = 1'b0;
                rd_oe_bad  = 1'b0;
            end else if (mon_active) begin
                m_cyc++;
            end
            if (mon_active) begin
                if (ale) n_ale++;
                if ($countones({!psen_b, !rd_b, !wr_b}) > 1) overlap = 1'b1;
                if (ale && (!psen_b || !rd_b || !wr_b)) overlap = 1'b1;
                if (!psen_b) n_psen++;
                if (!rd_b) n_rd++;
                if (!wr_b) begin
                    n_wr++;
                    if (n_wr == 1) wr_p0 = p0;
                    else if (p0 !== wr_p0) wr_bad = 1'b1;
                    if (!p0_oe) wr_bad = 1'b1;
                end
                if ((!psen_b || !rd_b) && p0_oe) rd_oe_bad = 1'b1;
            end
            if (done) begin
                if (!mon_active || sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with %0d pending, expected none (t=%0t)",
                             sb.size(), $time);
                end else begin
                    logic [23:0] cnt_act, cnt_exp;
                    e = sb.pop_front();
                    cnt_act = {n_psen[7:0], n_rd[7:0], n_wr[7:0]};
                    cnt_exp = {(e.kind == 0) ? 8'(SW + 1) : 8'd0,
                               (e.kind == 1) ? 8'(SW + 1) : 8'd0,
                               (e.kind == 2) ? 8'(SW + 1) : 8'd0};
                    chk("addr_phase", {16'd0, m_addr}, {16'd0, e.addr});
                    chk("strobe_cnt", {8'd0, cnt_act}, {8'd0, cnt_exp});
                    chk("latency", m_cyc, 3 + SW);
                    chk("ale_once_no_overlap", {overlap, n_ale[7:0]}, {1'b0, 8'd1});
                    chk("p2_hold", {24'd0, p2}, {24'd0, e.addr[15:8]});
                    if (e.kind == 2) begin
                        chk("wr_data_strobe", {wr_bad, wr_p0}, {1'b0, e.wdata});
                        chk("wr_data_hold", {p0_oe, p0}, {1'b1, e.wdata});
                        chk("data_o_held", {24'd0, data_o}, {24'd0, last_rd});
                    end else begin
                        chk("rd_data", {24'd0, data_o}, {24'd0, e.rdata});
                        chk("rd_p0_released", {31'd0, rd_oe_bad}, 32'd0);
                        last_rd = e.rdata;
                    end
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          nbusy;
        logic        seen;
        int          kind;
        logic [15:0] a;
        logic [7:0]  d, r, hi;

        repeat (2) @(negedge clk);
        chk("rst_data_p0_p2", {8'd0, data_o, p0, p2}, 32'd0);
        chk("rst_busy_done_oe_ale", {28'd0, busy, done, p0_oe, ale}, 32'd0);
        chk("rst_ea_strobes", {28'd0, ea_b, psen_b, rd_b, wr_b}, 32'hF);
        rst = 1'b0;
        @(negedge clk);

        do_txn(0, 16'h1234, 8'h00, 8'hA5, "rom_1234_done");
        do_txn(2, 16'h0042, 8'h5C, 8'h00, "ram_wr_0042_done");

        // ROM and RAM read together: ROM first, then one IDLE cycle, then RAM read.
        issue(0, 16'h0123, 8'h00, 8'h3C);
        issue(1, 16'h0123, 8'h00, 8'h3C);
        wait_done("prio_rom_done");
        @(negedge clk);
        chk("prio_idle_gap", {31'd0, busy}, 32'd0);
        wait_done("prio_rdr_done");
        rom_b = 1'b1;
        rdr_b = 1'b1;
        @(negedge clk);

        // Held ROM strobe: address change re-runs, constant address does not.
        issue(0, 16'h2000, 8'h00, 8'h11);
        wait_done("held_first_done");
        issue(0, 16'h2001, 8'h00, 8'h22);
        wait_done("held_second_done");
        nbusy = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) nbusy++;
        end
        chk("held_no_rerun", nbusy, 0);
        rom_b = 1'b1;
        @(negedge clk);

        // Reset during the strobe phase aborts the cycle with no done pulse.
        issue(0, 16'h3456, 8'h00, 8'h77);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!psen_b) seen = 1'b1;
        end
        chk("abort_reached_strobe", {31'd0, seen}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_async_release", {29'd0, psen_b, busy, done}, {29'd0, 3'b100});
        void'(sb.pop_back());
        rom_b = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        do_txn(0, 16'h3456, 8'h00, 8'h78, "post_reset_done");

        // EA_b synchroniser latency.
        @(posedge clk);
        #1 ea_pin = 1'b0;
        @(posedge clk);
        #1 chk("ea_first_edge", {31'd0, ea_b}, 32'd1);
        @(posedge clk);
        #1 chk("ea_second_edge", {31'd0, ea_b}, 32'd0);
        ea_pin = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            a    = 16'($urandom);
            if (kind != 0 && $urandom_range(0, 1) == 1) a[15:8] = 8'h00;
            d = 8'($urandom);
            r = 8'($urandom);
            issue(kind, a, d, r);
            wait_done("rand_done");
            if ($urandom_range(0, 2) == 0) begin
                hi = (a[15:8] == 8'h00) ? 8'h00 : 8'($urandom);
                a  = a ^ {hi, 8'($urandom_range(1, 255))};
                issue(kind, a, 8'($urandom), 8'($urandom));
                wait_done("rand_held_done");
            end
            set_strobe(kind, 1'b1);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
